fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the single-cycle CPU, directly upstream of the decoder. It holds the program counter, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents it with a valid/ready handshake. It computes the next PC from the decoder's control-flow outputs (`jump_type`, `jump_addr`, `imm`) plus `alu_zero` and `rs1_data` from execute. Misaligned targets raise a sticky error.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  byte address of fetch; stable while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle. Ignored when `imem_req`=0.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction presented to the decoder.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  downstream consumes `instr` this cycle. Control-flow inputs are sampled only when `instr_valid && instr_ready`.
- `jump_type`  in  3  000 sequential; 001 BEQ; 011 register/JAL jump; 100 J. Other codes are treated as 000.
- `is_jr`  in  1  with 011, selects `rs1_data` as the target; when 0, 011 is JAL (J-style target).
- `jump_addr`  in  32  J-type index; only bits [25:0] are used.
- `imm`  in  32  sign-extended branch offset in words.
- `alu_zero`  in  1  BEQ condition (rs == rt).
- `rs1_data`  in  32  register target for JR.
- `retired`  out  32  count of consumed instructions.
- `fetch_err`  out  1  sticky misaligned-target flag.

## Operation
- States:
  - RESET (held while `rst`=1).
  - FETCH: `imem_req`=1.
  - VALID: `instr_valid`=1.
  - ERROR: all outputs frozen except `fetch_err`=1.
- FETCH:
  - `imem_addr`=pc.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=pc, go to VALID.
  - Without ack: stay in FETCH with the address unchanged.
- VALID:
  - If `instr_ready`=0: hold `instr`/`instr_pc` unchanged.
  - On `instr_ready`=1: compute next_pc, `retired`<=`retired`+1.
  - If next_pc[1:0]≠0: go to ERROR. pc is not updated.
  - Otherwise pc<=next_pc and go to FETCH.
- next_pc, with pc4 = `instr_pc`+4:
  - 000: pc4.
  - 001: `alu_zero` ? pc4+(`imm`<<2) : pc4.
  - 011 with `is_jr`=1: `rs1_data`.
  - 011 with `is_jr`=0, or 100: {pc4[31:28], `jump_addr`[25:0], 2'b00}.
- Arithmetic: all additions modulo 2^32. `imm`<<2 is truncated to 32 bits. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- ERROR: exited only by `rst`. `imem_req`=0, `instr_valid`=0.
- Only one request is outstanding at a time. The instruction memory is reset by the same `rst`, so no stale ack exists after reset.

## Timing
- Reset values:
  - pc=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=0.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - `retired`=0, `fetch_err`=0.
- First cycle with `rst`=0: `imem_req`=1 and `imem_addr`=`RESET_PC`. Reset is registered, so the first request appears one cycle after `rst` falls.
- `imem_ack` may arrive in the same cycle `imem_req` first rises (zero wait). `instr_valid`=1 in the following cycle.
- Minimum throughput: 2 cycles per instruction (FETCH with ack, then VALID with ready).
- Consume handshake: `imem_req`=1 with the new `imem_addr` in the cycle after `instr_valid && instr_ready`. `instr_valid`=0 in that cycle.
- `rst` mid-operation (any state, including FETCH awaiting ack): next cycle equals the reset values. Any pending ack is discarded.
- `fetch_err` rises in the cycle after the offending consume.

## Test plan
- Reset, then sequential code with zero-wait ack: with `RESET_PC`=0, fetch addresses are 0,4,8,12. `retired`=3 after three consumes. `instr_valid` toggles with a 2-cycle period.
- Memory wait states (ack delayed 3 cycles) with `instr_ready` held low 2 cycles in VALID: `imem_addr` stays stable across the wait, `instr` holds, no duplicate request is issued.
- BEQ at pc=16 with `imm`=32'hFFFF_FFFE: `alu_zero`=1 gives next fetch 12; `alu_zero`=0 gives next fetch 20.
- J at pc=32'h4000_0000 with `jump_addr`=26'h10: next fetch 32'h4000_0040. JR with `rs1_data`=32'h100: next fetch 32'h100.
- JR with `rs1_data`=32'h102: `fetch_err`=1 the next cycle, `imem_req` stays 0, and the error persists until `rst`. After `rst`, refetch from `RESET_PC` with `fetch_err`=0.
- `rst` asserted while in FETCH with ack pending: all outputs return to reset values. After reset, the first request goes to `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, fetches over a req/ack
//               memory handshake and hands words downstream via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [2:0]  jump_type,
    input  logic        is_jr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] imm,
    input  logic        alu_zero,
    input  logic [31:0] rs1_data,
    output logic [31:0] retired,
    output logic        fetch_err
);

    localparam logic [1:0] c_st_reset = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_valid = 2'd2;
    localparam logic [1:0] c_st_error = 2'd3;

    localparam logic [2:0] c_jt_beq = 3'b001;
    localparam logic [2:0] c_jt_reg = 3'b011;
    localparam logic [2:0] c_jt_j   = 3'b100;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_imem_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_retired;
    logic        r_fetch_err;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_consume;
    logic        w_misaligned;
    logic        w_unused;

    // Only the J-type index field and the low 30 bits of the word offset matter
    assign w_unused = ^{jump_addr[31:26], imm[31:30]};

    always_comb begin
        w_pc4     = r_instr_pc + 32'd4;
        w_next_pc = w_pc4;
        case (jump_type)
            c_jt_beq: begin
                if (alu_zero) begin
                    w_next_pc = w_pc4 + {imm[29:0], 2'b00};
                end
            end
            c_jt_reg: begin
                w_next_pc = is_jr ? rs1_data : {w_pc4[31:28], jump_addr[25:0], 2'b00};
            end
            c_jt_j: begin
                w_next_pc = {w_pc4[31:28], jump_addr[25:0], 2'b00};
            end
            default: begin
                w_next_pc = w_pc4;
            end
        endcase
    end

    assign w_misaligned = (w_next_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        case (r_state)
            c_st_reset: w_state_nxt = c_st_fetch;
            c_st_fetch: begin
                if (imem_ack) begin
                    w_state_nxt = c_st_valid;
                end
            end
            c_st_valid: begin
                if (instr_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = w_misaligned ? c_st_error : c_st_fetch;
                end
            end
            default: w_state_nxt = c_st_error;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_reset;
            r_pc        <= RESET_PC;
            r_imem_addr <= 32'd0;
            r_instr     <= 32'd0;
            r_instr_pc  <= 32'd0;
            r_retired   <= 32'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_reset: r_imem_addr <= r_pc;
                c_st_fetch: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                    end
                end
                c_st_valid: begin
                    if (w_consume) begin
                        r_retired <= r_retired + 32'd1;
                        // A bad target leaves the PC untouched and parks in ERROR
                        if (w_misaligned) begin
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_pc        <= w_next_pc;
                            r_imem_addr <= w_next_pc;
                        end
                    end
                end
                default: begin
                    r_fetch_err <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == c_st_fetch);
    assign imem_addr   = r_imem_addr;
    assign instr_valid = (r_state == c_st_valid);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign retired     = r_retired;
    assign fetch_err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized self-checking bench for fetch_unit against a
//               behavioural PC/retire model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  jump_type;
    logic        is_jr;
    logic [31:0] jump_addr;
    logic [31:0] imm;
    logic        alu_zero;
    logic [31:0] rs1_data;
    logic [31:0] retired;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;

    fetch_unit #(.RESET_PC(c_reset_pc)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_type  (jump_type),
        .is_jr      (is_jr),
        .jump_addr  (jump_addr),
        .imm        (imm),
        .alu_zero   (alu_zero),
        .rs1_data   (rs1_data),
        .retired    (retired),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Spec-level next-PC rule, independent of how the RTL encodes it
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [2:0] jt,
                                               input logic jr, input logic [31:0] ja,
                                               input logic [31:0] im, input logic z,
                                               input logic [31:0] rs1);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (jt == 3'b001)
            return z ? pc4 + im * 32'd4 : pc4;
        if (jt == 3'b011 && jr)
            return rs1;
        if (jt == 3'b011 || jt == 3'b100)
            return (pc4 & 32'hF000_0000) | ((ja & 32'h03FF_FFFF) * 32'd4);
        return pc4;
    endfunction

    task automatic scramble_ctrl();
        jump_type = 3'($urandom);
        is_jr     = 1'($urandom);
        jump_addr = $urandom;
        imm       = $urandom;
        alu_zero  = 1'($urandom);
        rs1_data  = $urandom;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_err", 32'(fetch_err), 32'd0);
    endtask

    // Leaves the bench at a negedge in the first FETCH cycle
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = $urandom;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        exp_pc = c_reset_pc;
        exp_retired = 32'd0;
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, c_reset_pc);
    endtask

    // One full fetch/consume; returns 1 if the target was misaligned
    task automatic run_instr(input int ack_dly, input int rdy_dly, input logic [2:0] jt,
                             input logic jr, input logic [31:0] ja, input logic [31:0] im,
                             input logic z, input logic [31:0] rs1, output bit err);
        logic [31:0] data;
        logic [31:0] nxt;
        err = 1'b0;
        check_eq("req", 32'(imem_req), 32'd1);
        check_eq("addr", imem_addr, exp_pc);
        for (int i = 0; i < ack_dly; i++) begin
            scramble_ctrl();
            @(negedge clk);
            check_eq("wait_req", 32'(imem_req), 32'd1);
            check_eq("wait_addr", imem_addr, exp_pc);
            check_eq("wait_valid", 32'(instr_valid), 32'd0);
        end
        data = $urandom;
        imem_ack = 1'b1; imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        check_eq("valid", 32'(instr_valid), 32'd1);
        check_eq("instr", instr, data);
        check_eq("instr_pc", instr_pc, exp_pc);
        check_eq("no_req_valid", 32'(imem_req), 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            scramble_ctrl();
            imem_ack = 1'($urandom);
            @(negedge clk);
            imem_ack = 1'b0;
            check_eq("hold_valid", 32'(instr_valid), 32'd1);
            check_eq("hold_instr", instr, data);
            check_eq("hold_req", 32'(imem_req), 32'd0);
        end
        jump_type = jt; is_jr = jr; jump_addr = ja; imm = im; alu_zero = z; rs1_data = rs1;
        instr_ready = 1'b1;
        nxt = model_next(exp_pc, jt, jr, ja, im, z, rs1);
        exp_retired = exp_retired + 32'd1;
        @(negedge clk);
        instr_ready = 1'b0;
        scramble_ctrl();
        check_eq("retired", retired, exp_retired);
        check_eq("valid_drop", 32'(instr_valid), 32'd0);
        if (nxt[1:0] != 2'b00) begin
            err = 1'b1;
            check_eq("err_set", 32'(fetch_err), 32'd1);
            check_eq("err_req", 32'(imem_req), 32'd0);
        end else begin
            exp_pc = nxt;
            check_eq("err_clr", 32'(fetch_err), 32'd0);
            check_eq("next_req", 32'(imem_req), 32'd1);
            check_eq("next_addr", imem_addr, exp_pc);
        end
    endtask

    task automatic check_error_sticky();
        for (int i = 0; i < 3; i++) begin
            instr_ready = 1'b1; imem_ack = 1'b1;
            @(negedge clk);
            check_eq("sticky_err", 32'(fetch_err), 32'd1);
            check_eq("sticky_req", 32'(imem_req), 32'd0);
            check_eq("sticky_valid", 32'(instr_valid), 32'd0);
            check_eq("sticky_retired", retired, exp_retired);
        end
        instr_ready = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        bit err;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        scramble_ctrl();

        // Sequential zero-wait fetches: 0,4,8,12
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, 0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, err);
        check_eq("retired_3", retired, 32'd3);
        // Wait states and stalled consumer
        run_instr(3, 2, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, err);
        // BEQ at 16 taken -> 12, back to 16, not taken -> 20
        run_instr(0, 0, 3'b001, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b1, 32'd0, err);
        check_eq("beq_taken", imem_addr, 32'd12);
        run_instr(1, 0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, err);
        run_instr(0, 1, 3'b001, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b0, 32'd0, err);
        check_eq("beq_not_taken", imem_addr, 32'd20);
        // J within the 0x4 region, then JR
        run_instr(0, 0, 3'b011, 1'b1, 32'd0, 32'd0, 1'b0, 32'h4000_0000, err);
        run_instr(0, 0, 3'b100, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'd0, err);
        check_eq("j_target", imem_addr, 32'h4000_0040);
        run_instr(2, 0, 3'b011, 1'b1, 32'd0, 32'd0, 1'b0, 32'h0000_0100, err);
        check_eq("jr_target", imem_addr, 32'h0000_0100);
        // Wrap of the top word
        run_instr(0, 0, 3'b011, 1'b1, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, err);
        run_instr(0, 0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, err);
        check_eq("wrap_zero", imem_addr, 32'd0);
        // Misaligned JR -> sticky error until reset
        run_instr(0, 0, 3'b011, 1'b1, 32'd0, 32'd0, 1'b0, 32'h0000_0102, err);
        check_error_sticky();
        do_reset();
        // Reset while an ack is arriving in FETCH
        run_instr(0, 0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, err);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check_reset_vals();
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [31:0] rs1;
            rs1 = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            run_instr($urandom_range(0, 3), $urandom_range(0, 2), 3'($urandom), 1'($urandom),
                      $urandom, $urandom, 1'($urandom), rs1, err);
            if (err) begin
                check_error_sticky();
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
